// File: rtl/cpu_seq_pkg.sv
// Shared types for the accumulator CPU sequencer: state encoding and opcodes.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EX_LDA,
    ST_EX_STA,
    ST_EX_ADD,
    ST_EX_JMP,
    ST_ERROR
  } state_e;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait-state cycles of one memory access and flags when the
// tolerated number of extra cycles has been used up.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;

  // Saturates at TIMEOUT; the sequencer traps before it could count further.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (i_clear) begin
      r_wait_cnt <= '0;
    end else if (i_count_en && !o_expired) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  assign o_expired = (r_wait_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator datapath,
// including the memory handshake with a wait-state timeout trap.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op_code,
  input  logic       mem_ready,
  input  logic       halt,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       dbus_on_data,
  output logic       data_on_dbus,
  output logic       alu_on_dbus,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass,
  output logic       add,
  output logic       rd,
  output logic       wr,
  output logic       instr_done,
  output logic       halted,
  output logic       err
);

  state_e r_state;
  state_e w_next;
  logic   w_mem_access;
  logic   w_stall;
  logic   w_expired;

  // A cycle is a stall when a memory access is in flight and not yet acknowledged.
  assign w_mem_access = ((r_state == ST_FETCH) && !halt) ||
                        (r_state == ST_EX_LDA) || (r_state == ST_EX_STA);
  assign w_stall      = w_mem_access && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (!w_stall),
    .i_count_en (w_stall),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Controls are decoded from state so an async reset drops strobes at once.
  always_comb begin
    w_next       = r_state;
    ir_on_adr    = 1'b0;
    pc_on_adr    = 1'b0;
    dbus_on_data = 1'b0;
    data_on_dbus = 1'b0;
    alu_on_dbus  = 1'b0;
    ld_ir        = 1'b0;
    ld_ac        = 1'b0;
    ld_pc        = 1'b0;
    inc_pc       = 1'b0;
    clr_pc       = 1'b0;
    pass         = 1'b0;
    add          = 1'b0;
    rd           = 1'b0;
    wr           = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;

    case (r_state)
      ST_RST: begin
        clr_pc = 1'b1;
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt) begin
          halted = 1'b1;
        end else begin
          pc_on_adr    = 1'b1;
          rd           = 1'b1;
          data_on_dbus = 1'b1;
          if (mem_ready) begin
            ld_ir  = 1'b1;
            inc_pc = 1'b1;
            w_next = ST_DECODE;
          end else if (w_expired) begin
            w_next = ST_ERROR;
          end
        end
      end
      ST_DECODE: begin
        case (op_code)
          OP_LDA:  w_next = ST_EX_LDA;
          OP_STA:  w_next = ST_EX_STA;
          OP_ADD:  w_next = ST_EX_ADD;
          OP_JMP:  w_next = ST_EX_JMP;
          default: w_next = ST_RST;
        endcase
      end
      ST_EX_LDA: begin
        ir_on_adr    = 1'b1;
        rd           = 1'b1;
        data_on_dbus = 1'b1;
        if (mem_ready) begin
          ld_ac      = 1'b1;
          instr_done = 1'b1;
          w_next     = ST_FETCH;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end
      end
      ST_EX_STA: begin
        ir_on_adr    = 1'b1;
        pass         = 1'b1;
        alu_on_dbus  = 1'b1;
        dbus_on_data = 1'b1;
        wr           = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = ST_FETCH;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end
      end
      ST_EX_ADD: begin
        add         = 1'b1;
        alu_on_dbus = 1'b1;
        ld_ac       = 1'b1;
        instr_done  = 1'b1;
        w_next      = ST_FETCH;
      end
      ST_EX_JMP: begin
        ld_pc      = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_ERROR: begin
        err = 1'b1;
      end
      default: begin
        w_next = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against an instruction-level model.
module tb_cpu_sequencer;

  localparam int unsigned TIMEOUT = 3;

  localparam logic [16:0] B_IR_ADR  = 17'h10000;
  localparam logic [16:0] B_PC_ADR  = 17'h08000;
  localparam logic [16:0] B_DB_DATA = 17'h04000;
  localparam logic [16:0] B_DATA_DB = 17'h02000;
  localparam logic [16:0] B_ALU_DB  = 17'h01000;
  localparam logic [16:0] B_LD_IR   = 17'h00800;
  localparam logic [16:0] B_LD_AC   = 17'h00400;
  localparam logic [16:0] B_LD_PC   = 17'h00200;
  localparam logic [16:0] B_INC_PC  = 17'h00100;
  localparam logic [16:0] B_CLR_PC  = 17'h00080;
  localparam logic [16:0] B_PASS    = 17'h00040;
  localparam logic [16:0] B_ADD     = 17'h00020;
  localparam logic [16:0] B_RD      = 17'h00010;
  localparam logic [16:0] B_WR      = 17'h00008;
  localparam logic [16:0] B_DONE    = 17'h00004;
  localparam logic [16:0] B_HALTED  = 17'h00002;
  localparam logic [16:0] B_ERR     = 17'h00001;

  localparam logic [16:0] W_RST   = B_CLR_PC;
  localparam logic [16:0] W_DEC   = 17'h00000;
  localparam logic [16:0] W_FW    = B_PC_ADR | B_RD | B_DATA_DB;
  localparam logic [16:0] W_FD    = W_FW | B_LD_IR | B_INC_PC;
  localparam logic [16:0] W_LDA_W = B_IR_ADR | B_RD | B_DATA_DB;
  localparam logic [16:0] W_LDA_D = W_LDA_W | B_LD_AC | B_DONE;
  localparam logic [16:0] W_STA_W = B_IR_ADR | B_PASS | B_ALU_DB | B_DB_DATA | B_WR;
  localparam logic [16:0] W_STA_D = W_STA_W | B_DONE;
  localparam logic [16:0] W_ADD   = B_ADD | B_ALU_DB | B_LD_AC | B_DONE;
  localparam logic [16:0] W_JMP   = B_LD_PC | B_DONE;
  localparam logic [16:0] W_HALT  = B_HALTED;
  localparam logic [16:0] W_ERR   = B_ERR;

  typedef struct {
    logic        mr;
    logic        hl;
    logic [16:0] ctl;
    logic        ac_chk;
    logic [7:0]  ac;
    logic        adr_chk;
    logic [5:0]  adr;
  } vec_t;

  logic clk = 1'b0;
  logic reset, mem_ready, halt;
  logic [1:0] op_code;
  logic ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus, alu_on_dbus;
  logic ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, rd, wr;
  logic instr_done, halted, err;
  logic [16:0] ctl;

  // Datapath and memory environment, steered by the DUT's controls.
  logic [7:0] mem [64];
  logic [7:0] ir, ac;
  logic [5:0] pc;
  logic [5:0] last_adr;

  // Instruction-level reference model.
  logic [7:0] m_mem [64];
  logic [7:0] m_ac;
  logic [5:0] m_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign op_code = ir[7:6];
  assign ctl = {ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus, alu_on_dbus,
                ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, rd, wr,
                instr_done, halted, err};

  cpu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_code      (op_code),
    .mem_ready    (mem_ready),
    .halt         (halt),
    .ir_on_adr    (ir_on_adr),
    .pc_on_adr    (pc_on_adr),
    .dbus_on_data (dbus_on_data),
    .data_on_dbus (data_on_dbus),
    .alu_on_dbus  (alu_on_dbus),
    .ld_ir        (ld_ir),
    .ld_ac        (ld_ac),
    .ld_pc        (ld_pc),
    .inc_pc       (inc_pc),
    .clr_pc       (clr_pc),
    .pass         (pass),
    .add          (add),
    .rd           (rd),
    .wr           (wr),
    .instr_done   (instr_done),
    .halted       (halted),
    .err          (err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic both(input logic [16:0] s, input logic [16:0] a, input logic [16:0] b);
    return ((s & a) != 17'h0) && ((s & b) != 17'h0);
  endfunction

  function automatic logic inv_bad(input logic [16:0] s);
    return both(s, B_IR_ADR, B_PC_ADR) || both(s, B_ALU_DB, B_DATA_DB) ||
           both(s, B_RD, B_WR) || both(s, B_PASS, B_ADD) || both(s, B_LD_PC, B_INC_PC);
  endfunction

  function automatic vec_t mk(input logic mr, input logic hl, input logic [16:0] c,
                              input logic ac_chk, input logic [7:0] acv,
                              input logic adr_chk, input logic [5:0] adrv);
    vec_t v;
    v.mr = mr; v.hl = hl; v.ctl = c;
    v.ac_chk = ac_chk; v.ac = acv; v.adr_chk = adr_chk; v.adr = adrv;
    return v;
  endfunction

  // One clock: drive at negedge, sample 1ns later, then apply the datapath update after posedge.
  task automatic step(input logic mr, input logic hl, input logic rs,
                      input logic [16:0] exp, input string name);
    logic [16:0] s;
    @(negedge clk);
    mem_ready = mr;
    halt      = hl;
    reset     = rs;
    #1;
    s = ctl;
    check(name, 32'(s), 32'(exp));
    check({name, "/bus-exclusion"}, 32'(inv_bad(s)), 32'd0);
    last_adr = ((s & B_PC_ADR) != 17'h0) ? pc : ir[5:0];
    @(posedge clk);
    if (((s & B_WR) != 17'h0) && mr) mem[ir[5:0]] = ac;
    if ((s & B_LD_AC) != 17'h0)
      ac = ((s & B_ADD) != 17'h0) ? ac + {2'b00, ir[5:0]} : mem[ir[5:0]];
    if ((s & B_LD_IR) != 17'h0) ir = mem[pc];
    if ((s & B_CLR_PC) != 17'h0) pc = 6'd0;
    if ((s & B_INC_PC) != 17'h0) pc = pc + 6'd1;
    if ((s & B_LD_PC) != 17'h0) pc = ir[5:0];
    if (rs) ac = 8'h00;
  endtask

  initial begin
    vec_t tbl[$];
    logic [1:0] op;
    logic [5:0] a;
    int wf, wx, nh;

    reset = 1'b1; mem_ready = 1'b0; halt = 1'b0;
    ir = 8'h00; ac = 8'h00; pc = 6'd0; last_adr = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0]  = 8'h05; mem[1]  = 8'h83; mem[2]  = 8'hC7;
    mem[5]  = 8'h2A; mem[7]  = 8'h0B; mem[8]  = 8'h81;
    mem[9]  = 8'hCC; mem[10] = 8'h55; mem[11] = 8'hFF;
    mem[12] = 8'h86; mem[13] = 8'h4A;

    // LDA 5, ADD 3, JMP 7, LDA 11, ADD 1 (wrap), JMP 12, ADD 6, STA 10 with two waits.
    tbl.push_back(mk(1, 0, W_RST,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h00));
    tbl.push_back(mk(1, 0, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_LDA_D, 1, 8'h2A, 1, 6'h05));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h01));
    tbl.push_back(mk(0, 0, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(0, 0, W_ADD,   1, 8'h2D, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h02));
    tbl.push_back(mk(1, 1, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 1, W_JMP,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h07));
    tbl.push_back(mk(1, 0, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_LDA_D, 1, 8'hFF, 1, 6'h0B));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h08));
    tbl.push_back(mk(1, 0, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_ADD,   1, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h09));
    tbl.push_back(mk(1, 0, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_JMP,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h0C));
    tbl.push_back(mk(1, 0, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_ADD,   1, 8'h06, 0, 6'h00));
    tbl.push_back(mk(1, 0, W_FD,    0, 8'h00, 1, 6'h0D));
    tbl.push_back(mk(1, 0, W_DEC,   0, 8'h00, 0, 6'h00));
    tbl.push_back(mk(0, 0, W_STA_W, 0, 8'h00, 1, 6'h0A));
    tbl.push_back(mk(0, 0, W_STA_W, 0, 8'h00, 1, 6'h0A));
    tbl.push_back(mk(1, 0, W_STA_D, 1, 8'h06, 1, 6'h0A));

    step(1'b0, 1'b0, 1'b1, W_RST, "reset-hold");
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].mr, tbl[i].hl, 1'b0, tbl[i].ctl, $sformatf("vec%0d", i));
      if (tbl[i].adr_chk) check($sformatf("vec%0d/adr", i), 32'(last_adr), 32'(tbl[i].adr));
      if (tbl[i].ac_chk)  check($sformatf("vec%0d/ac", i), 32'(ac), 32'(tbl[i].ac));
    end
    check("sta-mem10", 32'(mem[10]), 32'h06);
    check("pc-after-sta", 32'(pc), 32'h0E);

    // Fetch timeout: TIMEOUT+1 read cycles, then a sticky trap.
    for (int i = 0; i <= int'(TIMEOUT); i++) step(1'b0, 1'b0, 1'b0, W_FW, $sformatf("tmo-rd%0d", i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i), 1'b0, W_ERR, $sformatf("tmo-err%0d", i));
    step(1'b1, 1'b0, 1'b1, W_RST, "tmo-reset");
    step(1'b1, 1'b0, 1'b0, W_RST, "tmo-rst-cycle");

    // Ready on the last allowed cycle completes normally; halt held during EX_LDA.
    for (int i = 0; i < int'(TIMEOUT); i++) step(1'b0, 1'b0, 1'b0, W_FW, $sformatf("last-rd%0d", i));
    step(1'b1, 1'b0, 1'b0, W_FD, "last-ok");
    check("last-ok/adr", 32'(last_adr), 32'h00);
    step(1'b1, 1'b1, 1'b0, W_DEC, "halt-dec");
    step(1'b1, 1'b1, 1'b0, W_LDA_D, "halt-lda");
    check("halt-lda/ac", 32'(ac), 32'h2A);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, W_HALT, $sformatf("halted%0d", i));
    step(1'b1, 1'b0, 1'b0, W_FD, "resume");
    check("resume/adr", 32'(last_adr), 32'h01);
    step(1'b1, 1'b0, 1'b0, W_DEC, "resume-dec");
    step(1'b1, 1'b0, 1'b0, W_ADD, "resume-add");
    check("resume-add/ac", 32'(ac), 32'h2D);

    // Reset in the middle of a stalled store.
    mem[2] = 8'h4A;
    step(1'b1, 1'b0, 1'b0, W_FD, "rsta-fetch");
    step(1'b1, 1'b0, 1'b0, W_DEC, "rsta-dec");
    step(1'b0, 1'b0, 1'b0, W_STA_W, "rsta-wr");
    step(1'b0, 1'b0, 1'b1, W_RST, "rsta-async-drop");
    step(1'b1, 1'b0, 1'b0, W_RST, "rsta-rst-cycle");
    step(1'b1, 1'b0, 1'b0, W_FD, "rsta-refetch");
    check("rsta-refetch/adr", 32'(last_adr), 32'h00);
    check("rsta-mem10", 32'(mem[10]), 32'h06);

    // Randomized program against the instruction-level model.
    for (int i = 0; i < 64; i++) begin
      mem[i]   = 8'($urandom);
      m_mem[i] = mem[i];
    end
    step(1'b0, 1'b0, 1'b1, W_RST, "rnd-reset");
    step(1'b1, 1'b0, 1'b0, W_RST, "rnd-rst-cycle");
    m_pc = 6'd0;
    m_ac = 8'h00;
    for (int k = 0; k < 300; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = 6'($urandom_range(0, 63));
      mem[m_pc]   = {op, a};
      m_mem[m_pc] = {op, a};
      nh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int h = 0; h < nh; h++) step(1'($urandom), 1'b1, 1'b0, W_HALT, "rnd-halt");
      wf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TIMEOUT)) : 0;
      wx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TIMEOUT)) : 0;
      for (int w = 0; w < wf; w++) step(1'b0, 1'b0, 1'b0, W_FW, "rnd-fetch-wait");
      step(1'b1, 1'b0, 1'b0, W_FD, "rnd-fetch");
      check("rnd-fetch/adr", 32'(last_adr), 32'(m_pc));
      step(1'($urandom), 1'($urandom), 1'b0, W_DEC, "rnd-dec");
      m_pc = m_pc + 6'd1;
      case (op)
        2'b00: begin
          for (int w = 0; w < wx; w++) step(1'b0, 1'($urandom), 1'b0, W_LDA_W, "rnd-lda-wait");
          step(1'b1, 1'($urandom), 1'b0, W_LDA_D, "rnd-lda");
          m_ac = m_mem[a];
        end
        2'b01: begin
          for (int w = 0; w < wx; w++) step(1'b0, 1'($urandom), 1'b0, W_STA_W, "rnd-sta-wait");
          step(1'b1, 1'($urandom), 1'b0, W_STA_D, "rnd-sta");
          m_mem[a] = m_ac;
          check("rnd-sta/mem", 32'(mem[a]), 32'(m_mem[a]));
        end
        2'b10: begin
          step(1'($urandom), 1'($urandom), 1'b0, W_ADD, "rnd-add");
          m_ac = m_ac + {2'b00, a};
        end
        default: begin
          step(1'($urandom), 1'($urandom), 1'b0, W_JMP, "rnd-jmp");
          m_pc = a;
        end
      endcase
      check("rnd/ac", 32'(ac), 32'(m_ac));
      check("rnd/pc", 32'(pc), 32'(m_pc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
